div_ctrl: RTL and testbench
===========================

DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port signed_div_i, input, 1 bit: 1 = signed divide (DIV), 0 = unsigned (DIVU); sampled at start acceptance.
REQ-004 SHALL have port opdata1_i, input, 32 bits: dividend; sampled at start acceptance.
REQ-005 SHALL have port opdata2_i, input, 32 bits: divisor; sampled at start acceptance.
REQ-006 SHALL have port start_i, input, 1 bit: division request from EX; held high by EX until ready_o is seen.
REQ-007 SHALL have port annul_i, input, 1 bit: cancel the in-flight division (pipeline flush).
REQ-008 SHALL have port result_o, output, 64 bits: {remainder[63:32], quotient[31:0]}, destined for HI/LO.
REQ-009 SHALL have port ready_o, output, 1 bit: result_o valid.
REQ-010 SHALL have port stallreq_o, output, 1 bit: pipeline stall request while a division is outstanding.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 SHALL accept a start at edge E0 when state=FREE, start_i=1, annul_i=0; all other FREE cycles stay in FREE.
REQ-013 SHALL, on acceptance with opdata2_i=0, go to BYZERO at E0 and to END at E1 with result_o=0.
REQ-014 SHALL, on acceptance with a nonzero divisor, go to ON at E0 with iteration counter=0.
REQ-015 SHALL latch operands at E0; for signed_div_i=1, each negative operand is replaced by its two's-complement magnitude.
REQ-016 SHALL run restoring shift-subtract in ON: one quotient bit per edge, MSB first, E1..E32, counter incrementing to 32.
REQ-017 SHALL, at the edge where state=ON and counter=32 (E33), go to END and load result_o.
REQ-018 SHALL, for signed mode, negate the quotient when the operand signs differ and give the remainder the dividend's sign.
REQ-019 SHALL use 32-bit wrap-around arithmetic: signed 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0.
REQ-020 SHALL drive ready_o=1 exactly while state=END, and 0 otherwise.
REQ-021 SHALL keep result_o stable while in END.
REQ-022 SHALL stay in END while start_i=1 and go to FREE on the first edge with start_i=0; ready_o falls with it.
REQ-023 SHALL drive stallreq_o = start_i AND NOT ready_o (combinational), so the pipeline stalls from request until the result cycle.
REQ-024 SHALL, when annul_i=1 in BYZERO or ON, go to FREE on that edge without asserting ready_o; result_o retains its previous value.
REQ-025 SHALL ignore annul_i in END; the result completes normally.
REQ-026 SHALL ignore operand changes on opdata1_i/opdata2_i/signed_div_i after E0.
REQ-027 SHALL have a start-to-ready latency of 33 edges for a nonzero divisor and 1 edge for a zero divisor.
REQ-028 SHALL NOT start a back-to-back division until FREE has been re-entered; the earliest re-accept is one edge after leaving END.

Reset
REQ-029 SHALL, on any edge with rst=1 and in any state, set state=FREE, counter=0, result_o=0, ready_o=0; the in-flight division is discarded.
REQ-030 SHALL give rst priority over start_i and annul_i.

Verification
REQ-031 SHALL be checked with unsigned 100/7, start held: at E33 ready_o=1 and result_o=0x00000002_0000000E; stallreq_o=1 from start until E33.
REQ-032 SHALL be checked with signed -7/2 (0xFFFFFFF9/0x00000002): at E33 result_o=0xFFFFFFFF_FFFFFFFD.
REQ-033 SHALL be checked with signed 0x80000000/0xFFFFFFFF: result_o=0x00000000_80000000 at E33.
REQ-034 SHALL be checked with divisor 0: BYZERO after E0, ready_o=1 with result_o=0 after E1; start_i dropped, then FREE and ready_o=0 next edge.
REQ-035 SHALL be checked with annul_i pulsed at E10: FREE next edge, ready_o never asserts, result_o unchanged; a new start is accepted on the following edge.
REQ-036 SHALL be checked with rst pulsed at E20: all outputs zero and state FREE after that edge; start_i still high re-starts at the next edge, giving a correct result 33 edges later.

Source files
------------

// File: rtl/div_ctrl_if.sv
// rtl/div_ctrl_if.sv - EX-stage divider request/result bundle
// The divider owns the slave side; the EX stage (or bench) drives the master side.
interface div_ctrl_if;
   logic        signed_div_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        start_i;
   logic        annul_i;
   logic [63:0] result_o;
   logic        ready_o;
   logic        stallreq_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - 32-bit restoring divider FSM (DIV/DIVU) producing {remainder, quotient}
// Operands are converted to magnitudes at acceptance; signs are reapplied when the result is loaded.
module div_ctrl (
   input  logic       clk,
   input  logic       rst,
   div_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quo_q, quo_d;
   logic [31:0] dvs_q, dvs_d;
   logic        neg_quo_q, neg_quo_d;
   logic        neg_rem_q, neg_rem_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;

   logic        op1_neg, op2_neg;
   logic [31:0] op1_abs, op2_abs;
   logic [32:0] rem_shift, diff;
   logic [31:0] quo_fix, rem_fix;

   always_comb begin
      op1_neg   = bus.signed_div_i & bus.opdata1_i[31];
      op2_neg   = bus.signed_div_i & bus.opdata2_i[31];
      op1_abs   = op1_neg ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
      op2_abs   = op2_neg ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
      // Partial remainder is always below the divisor, so 33 bits hold the shifted value.
      rem_shift = {rem_q, quo_q[31]};
      diff      = rem_shift - {1'b0, dvs_q};
      quo_fix   = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
      rem_fix   = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      ready_d   = ready_q;

      case (state_q)
         FREE: begin
            if (bus.start_i && !bus.annul_i) begin
               if (bus.opdata2_i == 32'd0) begin
                  state_d = BYZERO;
               end else begin
                  state_d   = ON;
                  cnt_d     = 6'd0;
                  rem_d     = 32'd0;
                  quo_d     = op1_abs;
                  dvs_d     = op2_abs;
                  neg_quo_d = op1_neg ^ op2_neg;
                  neg_rem_d = op1_neg;
               end
            end
         end
         BYZERO: begin
            if (bus.annul_i) begin
               state_d = FREE;
            end else begin
               state_d  = END;
               result_d = 64'd0;
               ready_d  = 1'b1;
            end
         end
         ON: begin
            if (bus.annul_i) begin
               state_d = FREE;
            end else if (cnt_q == 6'd32) begin
               state_d  = END;
               result_d = {rem_fix, quo_fix};
               ready_d  = 1'b1;
            end else begin
               // Dividend shifts out of quo_q MSB-first while quotient bits shift in.
               if (!diff[32]) begin
                  rem_d = diff[31:0];
                  quo_d = {quo_q[30:0], 1'b1};
               end else begin
                  rem_d = rem_shift[31:0];
                  quo_d = {quo_q[30:0], 1'b0};
               end
               cnt_d = cnt_q + 6'd1;
            end
         end
         END: begin
            if (!bus.start_i) begin
               state_d = FREE;
               ready_d = 1'b0;
            end
         end
         default: begin
            state_d = FREE;
            ready_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FREE;
         cnt_q     <= 6'd0;
         rem_q     <= 32'd0;
         quo_q     <= 32'd0;
         dvs_q     <= 32'd0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= 64'd0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
         ready_q   <= ready_d;
      end
   end

   assign bus.result_o   = result_q;
   assign bus.ready_o    = ready_q;
   assign bus.stallreq_o = bus.start_i & ~ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed scoreboard bench for div_ctrl
module tb_div_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   div_ctrl_if dif();

   div_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   int          total = 0;
   int          bad   = 0;
   logic [63:0] exp_q[$];
   logic [63:0] last_res = 64'd0;

   function automatic logic [63:0] model(input logic sg, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic sg, input logic [31:0] a, input logic [31:0] b);
      dif.signed_div_i = sg;
      dif.opdata1_i    = a;
      dif.opdata2_i    = b;
      dif.start_i      = 1'b1;
   endtask

   task automatic start_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
      drive(sg, a, b);
      exp_q.push_back(model(sg, a, b));
   endtask

   // Counts edges from the acceptance edge (E0) up to the edge that raises ready_o.
   task automatic wait_ready(input int lat, input string tag);
      int          n = 0;
      bit          stall_ok = 1'b1;
      logic [63:0] e;
      do begin
         tick();
         n++;
         if (n == 1) begin
            dif.signed_div_i = 1'($urandom);
            dif.opdata1_i    = $urandom;
            dif.opdata2_i    = $urandom;
         end
         if (!dif.ready_o && dif.stallreq_o !== 1'b1) stall_ok = 1'b0;
      end while (!dif.ready_o && n < 45);
      chk({tag, "_ready"}, 64'(dif.ready_o), 64'd1);
      chk({tag, "_latency"}, 64'(n - 1), 64'(lat));
      chk({tag, "_stall"}, 64'(stall_ok), 64'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({tag, "_result"}, dif.result_o, e);
         last_res = e;
      end else begin
         chk({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
      end
   endtask

   // Holds start (and annul) for one END cycle, then releases start.
   task automatic finish_div(input string tag);
      chk({tag, "_stall_at_ready"}, 64'(dif.stallreq_o), 64'd0);
      dif.annul_i = 1'b1;
      tick();
      dif.annul_i = 1'b0;
      chk({tag, "_ready_held"}, 64'(dif.ready_o), 64'd1);
      chk({tag, "_result_held"}, dif.result_o, last_res);
      dif.start_i = 1'b0;
      tick();
      chk({tag, "_ready_drop"}, 64'(dif.ready_o), 64'd0);
      chk({tag, "_result_kept"}, dif.result_o, last_res);
   endtask

   initial begin
      bit seen_ready;
      logic [31:0] ra, rb;
      logic        rs;

      rst              = 1'b1;
      dif.signed_div_i = 1'b0;
      dif.opdata1_i    = 32'd0;
      dif.opdata2_i    = 32'd0;
      dif.start_i      = 1'b0;
      dif.annul_i      = 1'b0;
      repeat (3) tick();
      chk("reset_ready", 64'(dif.ready_o), 64'd0);
      chk("reset_result", dif.result_o, 64'd0);
      chk("reset_stall", 64'(dif.stallreq_o), 64'd0);
      rst = 1'b0;
      tick();

      start_div(1'b0, 32'd100, 32'd7);
      chk("u100_7_model", exp_q[0], 64'h00000002_0000000E);
      wait_ready(33, "u100_7");
      finish_div("u100_7");

      start_div(1'b1, 32'hFFFFFFF9, 32'h00000002);
      wait_ready(33, "s_m7_2");
      chk("s_m7_2_const", dif.result_o, 64'hFFFFFFFF_FFFFFFFD);
      finish_div("s_m7_2");

      start_div(1'b1, 32'h80000000, 32'hFFFFFFFF);
      wait_ready(33, "s_min_m1");
      chk("s_min_m1_const", dif.result_o, 64'h00000000_80000000);
      finish_div("s_min_m1");

      start_div(1'b0, 32'd12345, 32'd0);
      wait_ready(1, "div_zero");
      finish_div("div_zero");

      // Annul: raised for the eleventh edge after acceptance (E10).
      drive(1'b0, 32'd1000, 32'd3);
      seen_ready = 1'b0;
      repeat (10) begin
         tick();
         if (dif.ready_o) seen_ready = 1'b1;
      end
      dif.annul_i = 1'b1;
      tick();
      dif.annul_i = 1'b0;
      chk("annul_never_ready", 64'(seen_ready | dif.ready_o), 64'd0);
      chk("annul_result_kept", dif.result_o, last_res);
      chk("annul_stall", 64'(dif.stallreq_o), 64'd1);
      start_div(1'b1, 32'hFFFFFC18, 32'd7);
      wait_ready(33, "after_annul");
      finish_div("after_annul");

      // Reset pulsed at E20 with start still high.
      start_div(1'b0, 32'hDEADBEEF, 32'd1234);
      repeat (20) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      last_res = 64'd0;
      chk("rst_mid_ready", 64'(dif.ready_o), 64'd0);
      chk("rst_mid_result", dif.result_o, 64'd0);
      wait_ready(33, "after_rst");
      finish_div("after_rst");

      for (int i = 0; i < 4; i++) begin
         rs = 1'($urandom);
         ra = $urandom;
         rb = (i == 3) ? 32'hFFFFFFFF : $urandom_range(1, 100000);
         if (i == 2) rb = ~rb + 32'd1;
         start_div(rs, ra, rb);
         wait_ready(33, $sformatf("rand%0d", i));
         finish_div($sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
